urv_dm_wb_bridge: RTL and testbench

- Data-memory bus master that sits directly downstream of the uRV CPU's data memory interface.
- Converts single-cycle load/store request pulses into Wishbone B4 pipelined single-beat cycles.
- Returns a one-cycle load_done/store_done pulse, with read data on loads.
- Adds a bus timeout and an error indication so a dead slave cannot hang the writeback stage.

---
 rtl/urv_dm_wb_bridge.sv | 170 +++++++++++++++++
 tb/tb_urv_dm_wb_bridge.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/urv_dm_wb_bridge.sv
// rtl/urv_dm_wb_bridge.sv - uRV data-memory port to Wishbone B4 pipelined single-beat master
// Adds a bus timeout and error reporting so a dead slave cannot stall the CPU writeback.
module urv_dm_wb_bridge #(
    parameter int unsigned g_timeout_cycles = 255,
    parameter logic [31:0] g_err_load_value = 32'h00000000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    input  logic        dm_store_i,
    input  logic        dm_load_i,
    output logic [31:0] dm_data_l_o,
    output logic        dm_load_done_o,
    output logic        dm_store_done_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_stall_i,
    output logic        bus_error_o,
    output logic        protocol_err_o
);

    localparam int unsigned CNT_W = (g_timeout_cycles > 0) ? $clog2(g_timeout_cycles + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(g_timeout_cycles);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((g_timeout_cycles > 0) ? g_timeout_cycles - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_ACK
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cyc_q, cyc_d;
    logic             stb_q, stb_d;
    logic             we_q, we_d;
    logic [31:0]      adr_q, adr_d;
    logic [3:0]       sel_q, sel_d;
    logic [31:0]      dat_q, dat_d;
    logic [31:0]      dl_q, dl_d;
    logic             ld_q, ld_d;
    logic             sd_q, sd_d;
    logic             be_q, be_d;
    logic             pe_q, pe_d;

    logic active;
    logic req_any;
    logic resp_ok;
    logic timeout_hit;
    logic fault;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        we_d    = we_q;
        adr_d   = adr_q;
        sel_d   = sel_q;
        dat_d   = dat_q;
        dl_d    = dl_q;
        ld_d    = 1'b0;
        sd_d    = 1'b0;
        be_d    = 1'b0;
        pe_d    = 1'b0;
        fault   = 1'b0;

        active      = (state_q != S_IDLE);
        req_any     = dm_load_i | dm_store_i;
        // A response during REQ only counts in the cycle the slave accepts the strobe.
        resp_ok     = active && (wb_ack_i || wb_err_i) && ((state_q == S_WAIT_ACK) || !wb_stall_i);
        timeout_hit = active && (g_timeout_cycles != 0) && (cnt_q == CNT_LAST);

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (dm_load_i && dm_store_i) begin
                    pe_d = 1'b1;
                end else if (req_any) begin
                    state_d = S_REQ;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    we_d    = dm_store_i;
                    adr_d   = dm_addr_i;
                    sel_d   = dm_data_select_i;
                    dat_d   = dm_data_s_i;
                end
            end
            S_REQ: begin
                pe_d = req_any;
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
                if (!wb_stall_i) begin
                    stb_d   = 1'b0;
                    state_d = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                pe_d = req_any;
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
            end
            default: state_d = S_IDLE;
        endcase

        // A real response beats a coincident timeout; ack together with err is an error.
        if (resp_ok || timeout_hit) begin
            fault   = !resp_ok || wb_err_i;
            state_d = S_IDLE;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            ld_d    = !we_q;
            sd_d    = we_q;
            be_d    = fault;
            if (!we_q) dl_d = fault ? g_err_load_value : wb_dat_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            sel_q   <= '0;
            dat_q   <= '0;
            dl_q    <= '0;
            ld_q    <= 1'b0;
            sd_q    <= 1'b0;
            be_q    <= 1'b0;
            pe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
            dl_q    <= dl_d;
            ld_q    <= ld_d;
            sd_q    <= sd_d;
            be_q    <= be_d;
            pe_q    <= pe_d;
        end
    end

    assign wb_cyc_o        = cyc_q;
    assign wb_stb_o        = stb_q;
    assign wb_we_o         = we_q;
    assign wb_adr_o        = adr_q;
    assign wb_sel_o        = sel_q;
    assign wb_dat_o        = dat_q;
    assign dm_data_l_o     = dl_q;
    assign dm_load_done_o  = ld_q;
    assign dm_store_done_o = sd_q;
    assign bus_error_o     = be_q;
    assign protocol_err_o  = pe_q;

endmodule

// File: tb/tb_urv_dm_wb_bridge.sv
// tb/tb_urv_dm_wb_bridge.sv - self-checking bench for urv_dm_wb_bridge
// Expected timelines are derived per transaction from stall/response delays and the timeout.
module tb_urv_dm_wb_bridge;

    localparam int          TMO  = 8;
    localparam logic [31:0] ERRV = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic [31:0] dm_addr_i, dm_data_s_i, dm_data_l_o, wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  dm_data_select_i, wb_sel_o;
    logic        dm_store_i, dm_load_i, dm_load_done_o, dm_store_done_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i, wb_err_i, wb_stall_i;
    logic        bus_error_o, protocol_err_o;

    always #5 clk = ~clk;

    urv_dm_wb_bridge #(
        .g_timeout_cycles(TMO),
        .g_err_load_value(ERRV)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n_i),
        .dm_addr_i(dm_addr_i), .dm_data_s_i(dm_data_s_i), .dm_data_select_i(dm_data_select_i),
        .dm_store_i(dm_store_i), .dm_load_i(dm_load_i),
        .dm_data_l_o(dm_data_l_o), .dm_load_done_o(dm_load_done_o), .dm_store_done_o(dm_store_done_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
        .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
        .wb_err_i(wb_err_i), .wb_stall_i(wb_stall_i),
        .bus_error_o(bus_error_o), .protocol_err_o(protocol_err_o)
    );

    // resp: 0 ack, 1 err, 2 ack+err, 3 silent slave; intr: cycle of a stray CPU load, -1 none
    typedef struct {
        bit          is_load;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  sel;
        int          stall;
        int          delay;
        int          resp;
        int          intr;
        bit          b2b;
    } txn_t;

    int n_checks = 0;
    int n_err    = 0;

    logic        m_we;
    logic [31:0] m_adr, m_dat, m_dl;
    logic [3:0]  m_sel;

    function automatic txn_t mk(input bit ld, input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rd, input logic [3:0] s, input int st,
                                input int dl, input int rs, input int it, input bit b2b);
        txn_t t;
        t.is_load = ld; t.addr = a; t.wdata = wd; t.rdata = rd; t.sel = s;
        t.stall = st; t.delay = dl; t.resp = rs; t.intr = it; t.b2b = b2b;
        return t;
    endfunction

    function automatic logic [106:0] act_vec();
        return {wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o, dm_data_l_o,
                dm_load_done_o, dm_store_done_o, bus_error_o, protocol_err_o};
    endfunction

    task automatic check(input string name, input logic [106:0] act, input logic [106:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        dm_load_i = 1'b0; dm_store_i = 1'b0;
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_stall_i = 1'b0;
    endtask

    task automatic run_txn(input txn_t t, input bit chained, input bit stop_at_done, input string tag);
        int accept, resp_cycle, c, last, stb_end;
        bit fault;
        logic [31:0] new_dl;
        accept     = 1 + t.stall;
        resp_cycle = accept + t.delay;
        if (t.resp != 3 && resp_cycle <= TMO) begin
            c = resp_cycle; fault = (t.resp != 0);
        end else begin
            c = TMO; fault = 1'b1;
        end
        stb_end = (accept < c) ? accept : c;
        new_dl  = t.is_load ? (fault ? ERRV : t.rdata) : m_dl;
        if (stop_at_done) last = c + 1;
        else if (t.resp != 3 && resp_cycle + 1 > c + 2) last = resp_cycle + 1;
        else last = c + 2;

        dm_load_i = t.is_load; dm_store_i = !t.is_load;
        dm_addr_i = t.addr; dm_data_s_i = t.wdata; dm_data_select_i = t.sel;
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_stall_i = 1'b0; wb_dat_i = t.rdata;
        if (!chained) begin
            @(negedge clk);
            check($sformatf("%s c0", tag), act_vec(),
                  {2'b00, m_we, m_adr, m_sel, m_dat, m_dl, 4'b0000});
        end
        @(posedge clk); #1;
        m_we = !t.is_load; m_adr = t.addr; m_sel = t.sel; m_dat = t.wdata;
        for (int j = 1; j <= last; j++) begin
            dm_load_i  = (j == t.intr);
            dm_store_i = 1'b0;
            dm_addr_i  = ~t.addr; dm_data_s_i = ~t.wdata; dm_data_select_i = ~t.sel;
            wb_stall_i = (j < accept);
            wb_ack_i   = (t.resp == 0 || t.resp == 2) && (j == resp_cycle);
            wb_err_i   = (t.resp == 1 || t.resp == 2) && (j == resp_cycle);
            @(negedge clk);
            check($sformatf("%s c%0d", tag, j), act_vec(),
                  {(j <= c), (j <= stb_end), m_we, m_adr, m_sel, m_dat,
                   (j > c) ? new_dl : m_dl,
                   (t.is_load && j == c + 1), (!t.is_load && j == c + 1),
                   (fault && j == c + 1), (t.intr > 0 && j == t.intr + 1)});
            if (!(stop_at_done && j == last)) begin
                @(posedge clk); #1;
            end
        end
        m_dl = new_dl;
        clear_inputs();
    endtask

    txn_t vec[10];
    txn_t t;
    bit   chain_prev, stop;
    int   acc_cap;

    initial begin
        vec[0] = mk(1, 32'h100, 32'h0, 32'hCAFEBABE, 4'hF, 0, 0, 0, -1, 0);
        vec[1] = mk(0, 32'h200, 32'h11223344, 32'h0, 4'b0011, 3, 2, 0, -1, 0);
        vec[2] = mk(1, 32'h300, 32'h0, 32'h55AA55AA, 4'hF, 0, 9, 0, -1, 0);
        vec[3] = mk(1, 32'h400, 32'h0, 32'h12345678, 4'hF, 0, 1, 1, -1, 0);
        vec[4] = mk(0, 32'h404, 32'hA5A5F00F, 32'h0, 4'b1100, 1, 1, 0, -1, 1);
        vec[5] = mk(1, 32'h500, 32'h0, 32'h87654321, 4'hF, 0, 0, 2, -1, 0);
        vec[6] = mk(1, 32'h504, 32'h0, 32'h0BADF00D, 4'hF, 1, 2, 0, 3, 0);
        vec[7] = mk(0, 32'h508, 32'h99887766, 32'h0, 4'hF, 9, 0, 0, -1, 0);
        vec[8] = mk(1, 32'h50C, 32'h0, 32'h13579BDF, 4'hF, 7, 0, 0, -1, 0);
        vec[9] = mk(1, 32'h510, 32'h0, 32'h2468ACE0, 4'hF, 0, 7, 0, -1, 0);

        rst_n_i = 1'b0;
        dm_addr_i = '0; dm_data_s_i = '0; dm_data_select_i = '0; wb_dat_i = '0;
        clear_inputs();
        m_we = 1'b0; m_adr = '0; m_sel = '0; m_dat = '0; m_dl = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset", act_vec(), 107'b0);
        @(posedge clk); #1;
        rst_n_i = 1'b1;

        for (int i = 0; i < 10; i++) begin
            stop = (i < 9) ? vec[i + 1].b2b : 1'b0;
            run_txn(vec[i], vec[i].b2b, stop, $sformatf("vec%0d", i));
        end

        // both request strobes at once while idle
        dm_load_i = 1'b1; dm_store_i = 1'b1; dm_addr_i = 32'hFFF0;
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        check("both_req pulse", act_vec(), {2'b00, m_we, m_adr, m_sel, m_dat, m_dl, 4'b0001});
        @(posedge clk); #1;
        @(negedge clk);
        check("both_req after", act_vec(), {2'b00, m_we, m_adr, m_sel, m_dat, m_dl, 4'b0000});
        @(posedge clk); #1;

        // reset asserted while waiting for an ack
        dm_load_i = 1'b1; dm_addr_i = 32'h600; dm_data_select_i = 4'hF;
        @(posedge clk); #1;
        clear_inputs();
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        check("pre_rst wait", act_vec(), {3'b100, 32'h600, 4'hF, dm_data_s_i, m_dl, 4'b0000});
        @(posedge clk); #2;
        rst_n_i = 1'b0;
        #1;
        check("async_rst", act_vec(), 107'b0);
        m_we = 1'b0; m_adr = '0; m_sel = '0; m_dat = '0; m_dl = '0;
        @(posedge clk); #1;
        rst_n_i = 1'b1;
        @(negedge clk);
        check("post_rst", act_vec(), 107'b0);
        @(posedge clk); #1;
        run_txn(mk(1, 32'h700, 32'h0, 32'hFEEDFACE, 4'hF, 0, 1, 0, -1, 0), 0, 0, "post_rst_ld");

        chain_prev = 1'b0;
        for (int k = 0; k < 40; k++) begin
            t.is_load = 1'($urandom_range(0, 1));
            t.addr    = $urandom;
            t.wdata   = $urandom;
            t.rdata   = $urandom;
            t.sel     = 4'($urandom_range(1, 15));
            t.stall   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(5, 10)) : int'($urandom_range(0, 3));
            t.delay   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(6, 11)) : int'($urandom_range(0, 3));
            t.resp    = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 3));
            acc_cap   = (t.stall + 1 < TMO) ? t.stall + 1 : TMO;
            t.intr    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, acc_cap)) : -1;
            t.b2b     = chain_prev;
            stop      = (k < 39) && ($urandom_range(0, 2) == 0);
            run_txn(t, chain_prev, stop, $sformatf("rnd%0d", k));
            chain_prev = stop;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
